// File: rtl/alu_md_if.sv
// Execute-stage bus between the ID/EX register and the ALU control /
// multiply-divide unit. The instruction source drives (master); the
// control block consumes and reports back (slave).
interface alu_md_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    logic              in_valid;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [SEL_W-1:0]  select;
    logic              illegal;
    logic              stall;
    logic              md_busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output in_valid, alu_op, funct, rs_val, rt_val,
        input  select, illegal, stall, md_busy, hi, lo
    );

    modport slave (
        input  in_valid, alu_op, funct, rs_val, rt_val,
        output select, illegal, stall, md_busy, hi, lo
    );
endinterface

// File: rtl/alu_md_control.sv
// ALU control decode plus an iterative multiply/divide unit owning HI/LO.
// Multiply is unsigned shift-add on operand magnitudes, divide is restoring
// division on magnitudes; signs are applied in a single FIX cycle.
module alu_md_control #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input logic     clk,
    input logic     rst,
    alu_md_if.slave bus
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              busy;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;

    // datapath registers (no reset: always loaded at issue)
    logic [DATA_W-1:0] p_hi;      // product high / partial remainder
    logic [DATA_W-1:0] p_lo;      // multiplier / quotient shifter
    logic [DATA_W-1:0] opb;       // multiplicand / divisor magnitude
    logic              is_div;
    logic              div0;
    logic              neg_q;     // product or quotient negative
    logic              neg_r;     // remainder takes dividend sign

    // decode outputs
    logic [3:0] sel;
    logic       undef;
    logic       hilo;
    logic       md_op;
    logic       sgn_op;
    logic       div_op;
    logic       mt_hi;
    logic       mt_lo;
    logic       stall;
    logic       issue;

    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                              input logic take);
        return (take && v[DATA_W-1]) ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic neg);
        return neg ? DATA_W'(-v) : v;
    endfunction

    // Decode alu_op/funct into select code and instruction class
    always_comb begin
        sel    = 4'b1111;
        undef  = 1'b0;
        hilo   = 1'b0;
        md_op  = 1'b0;
        sgn_op = 1'b0;
        div_op = 1'b0;
        mt_hi  = 1'b0;
        mt_lo  = 1'b0;
        case (bus.alu_op)
            2'b00: sel = 4'b0010;
            2'b01: sel = 4'b0110;
            2'b10: begin
                case (bus.funct)
                    6'b100000, 6'b100001: sel = 4'b0010;
                    6'b100010, 6'b100011: sel = 4'b0110;
                    6'b100100: sel = 4'b0000;
                    6'b100101: sel = 4'b0001;
                    6'b100110: sel = 4'b0011;
                    6'b100111: sel = 4'b0100;
                    6'b101010: sel = 4'b0111;
                    6'b101011: sel = 4'b1011;
                    6'b000000: sel = 4'b1000;
                    6'b000010: sel = 4'b1001;
                    6'b000011: sel = 4'b1010;
                    6'b010000: begin sel = 4'b1100; hilo = 1'b1; end
                    6'b010010: begin sel = 4'b1101; hilo = 1'b1; end
                    6'b010001: begin hilo = 1'b1; mt_hi = 1'b1; end
                    6'b010011: begin hilo = 1'b1; mt_lo = 1'b1; end
                    6'b011000: begin hilo = 1'b1; md_op = 1'b1; sgn_op = 1'b1; end
                    6'b011001: begin hilo = 1'b1; md_op = 1'b1; end
                    6'b011010: begin hilo = 1'b1; md_op = 1'b1; sgn_op = 1'b1; div_op = 1'b1; end
                    6'b011011: begin hilo = 1'b1; md_op = 1'b1; div_op = 1'b1; end
                    default:   undef = 1'b1;
                endcase
            end
            default: undef = 1'b1;
        endcase
    end

    assign stall       = bus.in_valid & hilo & busy;
    assign issue       = bus.in_valid & ~stall & md_op;
    assign bus.select  = SEL_W'(sel);
    assign bus.illegal = bus.in_valid & undef;
    assign bus.stall   = stall;
    assign bus.md_busy = busy;
    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;

    // one step of each algorithm
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W-1:0] rem_sh;
    logic              rem_ge;
    logic [DATA_W-1:0] rem_sub;

    always_comb begin
        mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : '0);
        rem_sh  = {p_hi[DATA_W-2:0], p_lo[DATA_W-1]};
        rem_ge  = {p_hi, p_lo[DATA_W-1]} >= {1'b0, opb};
        rem_sub = rem_sh - opb;
    end

    // sign-corrected results written at FIX
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   fix_hi;
    logic [DATA_W-1:0]   fix_lo;

    always_comb begin
        prod_fix = neg_q ? (2*DATA_W)'(-{p_hi, p_lo}) : {p_hi, p_lo};
        if (is_div) begin
            fix_lo = div0 ? '1 : cond_neg(p_lo, neg_q);
            fix_hi = cond_neg(p_hi, neg_r);
        end else begin
            fix_hi = prod_fix[2*DATA_W-1:DATA_W];
            fix_lo = prod_fix[DATA_W-1:0];
        end
    end

    // Operand capture at issue and one iteration per RUN cycle
    always_ff @(posedge clk) begin
        if (issue) begin
            p_hi   <= '0;
            p_lo   <= div_op ? mag(bus.rs_val, sgn_op) : mag(bus.rt_val, sgn_op);
            opb    <= div_op ? mag(bus.rt_val, sgn_op) : mag(bus.rs_val, sgn_op);
            is_div <= div_op;
            div0   <= div_op && (bus.rt_val == '0);
            neg_q  <= sgn_op && (bus.rs_val[DATA_W-1] ^ bus.rt_val[DATA_W-1]);
            neg_r  <= sgn_op && bus.rs_val[DATA_W-1];
        end else if (state == RUN) begin
            if (is_div) begin
                p_hi <= rem_ge ? rem_sub : rem_sh;
                p_lo <= {p_lo[DATA_W-2:0], rem_ge};
            end else begin
                p_hi <= mul_sum[DATA_W:1];
                p_lo <= {mul_sum[0], p_lo[DATA_W-1:1]};
            end
        end
    end

    // Control FSM and HI/LO architectural registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else if (bus.in_valid && !stall) begin
                        if (mt_hi) hi_r <= bus.rs_val;
                        if (mt_lo) lo_r <= bus.rs_val;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1)) state <= FIX;
                end
                FIX: begin
                    hi_r  <= fix_hi;
                    lo_r  <= fix_lo;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md_control.sv
// Directed bench for alu_md_control at DATA_W=32: decode table, multiply/
// divide results and latency, HI/LO stall behaviour, MTHI/MTLO, reset.
module tb_alu_md_control;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu_md_if #(.DATA_W(32), .SEL_W(4)) bus ();

    alu_md_control #(.DATA_W(32), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] sel;
        logic       ill;
    } dec_vec_t;

    dec_vec_t dv[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive an MD instruction for exactly one issue edge
    task automatic issue_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.alu_op   = 2'b10;
        bus.funct    = f;
        bus.rs_val   = a;
        bus.rt_val   = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_md(input string nm, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        issue_op(f, a, b);
        n = 0;
        while (bus.md_busy && n < 100) begin
            n++;
            tick();
        end
        chk({nm, "_busy_cycles"}, 64'(n), 64'd33);
        chk({nm, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({nm, "_lo"}, 64'(bus.lo), 64'(el));
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.alu_op   = 2'b00;
        bus.funct    = 6'b0;
        bus.rs_val   = '0;
        bus.rt_val   = '0;

        dv.push_back('{1'b1, 2'b00, 6'b000000, 4'b0010, 1'b0});
        dv.push_back('{1'b1, 2'b01, 6'b000000, 4'b0110, 1'b0});
        dv.push_back('{1'b1, 2'b11, 6'b000000, 4'b1111, 1'b1});
        dv.push_back('{1'b0, 2'b11, 6'b000000, 4'b1111, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b100000, 4'b0010, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b100001, 4'b0010, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b100010, 4'b0110, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b100011, 4'b0110, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b100100, 4'b0000, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b100101, 4'b0001, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b100110, 4'b0011, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b100111, 4'b0100, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b101010, 4'b0111, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b101011, 4'b1011, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b000000, 4'b1000, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b000010, 4'b1001, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b000011, 4'b1010, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b010000, 4'b1100, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b010010, 4'b1101, 1'b0});
        dv.push_back('{1'b1, 2'b10, 6'b111111, 4'b1111, 1'b1});
        dv.push_back('{1'b0, 2'b10, 6'b111111, 4'b1111, 1'b0});
        dv.push_back('{1'b0, 2'b10, 6'b011000, 4'b1111, 1'b0});
        dv.push_back('{1'b0, 2'b10, 6'b011001, 4'b1111, 1'b0});
        dv.push_back('{1'b0, 2'b10, 6'b011010, 4'b1111, 1'b0});
        dv.push_back('{1'b0, 2'b10, 6'b011011, 4'b1111, 1'b0});
        dv.push_back('{1'b0, 2'b10, 6'b010001, 4'b1111, 1'b0});
        dv.push_back('{1'b0, 2'b10, 6'b010011, 4'b1111, 1'b0});

        // reset state
        tick();
        chk("rst_busy", 64'(bus.md_busy), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        rst = 1'b0;
        tick();

        // decode sweep
        foreach (dv[i]) begin
            bus.in_valid = dv[i].v;
            bus.alu_op   = dv[i].op;
            bus.funct    = dv[i].f;
            #1;
            chk($sformatf("dec%0d_sel", i), 64'(bus.select), 64'(dv[i].sel));
            chk($sformatf("dec%0d_ill", i), 64'(bus.illegal), 64'(dv[i].ill));
            chk($sformatf("dec%0d_stall", i), 64'(bus.stall), 64'd0);
            tick();
        end
        bus.in_valid = 1'b0;

        // multiply / divide results
        run_md("mult_neg", 6'b011000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_md("div_neg", 6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("div_negdvs", 6'b011010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        run_md("divu", 6'b011011, 32'd7, 32'd2, 32'd1, 32'd3);
        run_md("divu_zero", 6'b011011, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
        run_md("div_zero_neg", 6'b011010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_md("div_min", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_md("multu_big", 6'b011001, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 32'h242D2080);

        // MTHI / MTLO leave the other register alone
        bus.in_valid = 1'b1;
        bus.alu_op   = 2'b10;
        bus.funct    = 6'b010001;
        bus.rs_val   = 32'hA5A5A5A5;
        tick();
        bus.in_valid = 1'b0;
        chk("mthi_hi", 64'(bus.hi), 64'h00000000A5A5A5A5);
        chk("mthi_lo", 64'(bus.lo), 64'h00000000242D2080);
        bus.in_valid = 1'b1;
        bus.funct    = 6'b010011;
        bus.rs_val   = 32'h5A5A0001;
        tick();
        bus.in_valid = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'h000000005A5A0001);
        chk("mtlo_hi", 64'(bus.hi), 64'h00000000A5A5A5A5);

        // overlap of non-HI/LO ops with busy unit, then MFLO stall
        issue_op(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("ovl_busy", 64'(bus.md_busy), 64'd1);
        bus.in_valid = 1'b1;
        bus.funct    = 6'b100000;
        #1;
        chk("ovl_add_stall", 64'(bus.stall), 64'd0);
        chk("ovl_add_sel", 64'(bus.select), 64'b0010);
        tick();
        bus.funct = 6'b101010;
        #1;
        chk("ovl_slt_stall", 64'(bus.stall), 64'd0);
        chk("ovl_slt_sel", 64'(bus.select), 64'b0111);
        tick();
        bus.funct = 6'b010010;
        #1;
        chk("mflo_stall", 64'(bus.stall), 64'd1);
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            tick();
        end
        chk("mflo_release", 64'(bus.stall | bus.md_busy), 64'd0);
        chk("mflo_sel", 64'(bus.select), 64'b1101);
        chk("mflo_lo", 64'(bus.lo), 64'h0000000000000001);
        chk("mflo_hi", 64'(bus.hi), 64'h00000000FFFFFFFE);
        bus.in_valid = 1'b0;
        tick();

        // reset in the middle of a MULT
        issue_op(6'b011000, 32'hFFFFFFFE, 32'd3);
        for (int k = 0; k < 10; k++) tick();
        chk("mid_busy_pre", 64'(bus.md_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(bus.md_busy), 64'd0);
        chk("mid_rst_hi", 64'(bus.hi), 64'd0);
        chk("mid_rst_lo", 64'(bus.lo), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 64'(bus.md_busy), 64'd0);
        run_md("post_rst_mult", 6'b011000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
